// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: 8N1 UART receiver with frame-error detection and an
// operand-select flag that toggles on every good byte.
//
// Handshake: uart_signal is a one-cycle valid strobe with no ready; the
// consumer must take uart_rx_data during the strobe. uart_rx_data holds its
// value until the next good frame, so a late read still sees the last byte.
//
// The stop-bit decision is registered once (stop_ok / stop_bad) and the
// outputs are registered from it one edge later. This gives the strobe its
// fixed latency of 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles from the
// start edge. It also leaves the FSM back in IDLE before the strobe, so a
// back-to-back start bit is never missed.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    output logic [7:0] uart_rx_data,
    output logic       uart_signal,
    output logic       uart_flag,
    output logic       frame_err,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift_reg;
    logic          sync_1;
    logic          rx_s;
    logic          stop_ok;
    logic          stop_bad;

    // Two-flop synchronizer; both flops idle high so reset never fakes a start.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= uart_rx;
            rx_s   <= sync_1;
        end
    end

    // Frame FSM: walks start / data / stop sample points and records the verdict.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            stop_ok   <= 1'b0;
            stop_bad  <= 1'b0;
        end else begin
            stop_ok  <= 1'b0;
            stop_bad <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end else begin
                            // Line went back high before mid-start: a glitch.
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt                <= '0;
                        shift_reg[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        stop_ok  <= rx_s;
                        stop_bad <= !rx_s;
                        state    <= rx_s ? IDLE : WAIT_HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must go high before a new start is allowed.
                    cnt <= '0;
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Output stage: strobes, data capture and flag toggle on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_rx_data <= 8'h00;
            uart_signal  <= 1'b0;
            uart_flag    <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            uart_signal <= stop_ok;
            frame_err   <= stop_bad;
            if (stop_ok) begin
                uart_rx_data <= shift_reg;
                uart_flag    <= ~uart_flag;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed scenarios plus randomized frames for uart_rx_ctrl.
// The reference model is a queue of bytes that should arrive, a count of
// frames that should be rejected, and the operand flag as the parity of
// good bytes since reset.
module tb_uart_rx_ctrl;

    localparam int N = 16;

    logic       clk;
    logic       rst;
    logic       uart_rx;
    logic [7:0] uart_rx_data;
    logic       uart_signal;
    logic       uart_flag;
    logic       frame_err;
    logic       busy;

    uart_rx_ctrl #(.CLKS_PER_BIT(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .uart_rx      (uart_rx),
        .uart_rx_data (uart_rx_data),
        .uart_signal  (uart_signal),
        .uart_flag    (uart_flag),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    // ---------------- clock / reset block ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int         vectors    = 0;
    int         miscompares = 0;
    int         exp_err    = 0;
    int         err_seen   = 0;
    int         exp_good   = 0;
    int         good_seen  = 0;
    logic       model_flag = 1'b0;
    logic [7:0] model_data = 8'h00;
    int         start_edge = 0;
    int         last_sig_cyc = 0;
    logic       prev_sig   = 1'b0;
    logic       prev_ferr  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: every strobe is matched against the expected byte queue.
    always @(negedge clk) begin
        if (uart_signal) begin
            check_eq("sig_width", 32'(prev_sig), 32'd0);
            check_eq("sig_ferr_excl", 32'(frame_err), 32'd0);
            check_eq("byte_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                model_data = exp_q.pop_front();
                check_eq("rx_data", 32'(uart_rx_data), 32'(model_data));
                model_flag = ~model_flag;
                check_eq("flag", 32'(uart_flag), 32'(model_flag));
            end
            good_seen++;
            last_sig_cyc = cyc;
        end
        if (frame_err) begin
            check_eq("ferr_width", 32'(prev_ferr), 32'd0);
            err_seen++;
        end
        prev_sig  = uart_signal;
        prev_ferr = frame_err;
    end

    // ---------------- driver tasks ----------------
    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data"}, 32'(uart_rx_data), 32'h00);
        check_eq({tag, "_sig"},  32'(uart_signal),  32'd0);
        check_eq({tag, "_flag"}, 32'(uart_flag),    32'd0);
        check_eq({tag, "_ferr"}, 32'(frame_err),    32'd0);
        check_eq({tag, "_busy"}, 32'(busy),         32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_rx = 1'b1;
        model_flag = 1'b0;
        model_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
    endtask

    // Entered and left on a negedge; each bit is held N cycles.
    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic glitch);
        start_edge = cyc + 1;
        uart_rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            if (glitch) begin
                // Short flip early in the bit, well away from the mid-bit sample.
                repeat (2) @(negedge clk);
                uart_rx = ~d[i];
                repeat (2) @(negedge clk);
                uart_rx = d[i];
                repeat (N - 4) @(negedge clk);
            end else begin
                repeat (N) @(negedge clk);
            end
        end
        if (stop_bit) begin
            exp_q.push_back(d);
            exp_good++;
        end else begin
            exp_err++;
        end
        uart_rx = stop_bit;
        repeat (N) @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 4 * N && exp_q.size() != 0; i++) @(negedge clk);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int good_before;
        int err_before;
        logic [7:0] d;
        logic       ok;
        logic       gl;

        rst = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        // Idle line: nothing may happen.
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            check_eq("idle_busy", 32'(busy), 32'd0);
            check_eq("idle_sig",  32'(uart_signal), 32'd0);
            check_eq("idle_data", 32'(uart_rx_data), 32'h00);
        end

        // Single byte with latency measurement.
        send_frame(8'hA5, 1'b1, 1'b0);
        drain("a5_drain");
        check_eq("a5_latency", 32'(last_sig_cyc - start_edge), 32'd155);
        check_eq("a5_data", 32'(uart_rx_data), 32'hA5);
        check_eq("a5_flag", 32'(uart_flag), 32'd1);

        // Back-to-back frames.
        do_reset();
        repeat (4) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        drain("b2b_drain");
        check_eq("b2b_data", 32'(uart_rx_data), 32'h34);
        check_eq("b2b_flag", 32'(uart_flag), 32'd0);

        // 4-cycle glitch on an idle line.
        repeat (2 * N) @(negedge clk);
        good_before = good_seen;
        err_before  = err_seen;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        @(negedge clk);
        check_eq("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (8) @(negedge clk);
        check_eq("glitch_busy_lo", 32'(busy), 32'd0);
        repeat (2 * N) @(negedge clk);
        check_eq("glitch_no_byte", 32'(good_seen - good_before), 32'd0);
        check_eq("glitch_no_ferr", 32'(err_seen - err_before), 32'd0);

        // Bad stop bit followed by a held-low break, then a good frame.
        do_reset();
        repeat (4) @(negedge clk);
        send_frame(8'hFF, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check_eq("brk_busy", 32'(busy), 32'd1);
        check_eq("brk_ferr_cnt", 32'(err_seen), 32'(exp_err));
        check_eq("brk_data", 32'(uart_rx_data), 32'(model_data));
        check_eq("brk_flag", 32'(uart_flag), 32'(model_flag));
        uart_rx = 1'b1;
        repeat (N) @(negedge clk);
        check_eq("brk_release", 32'(busy), 32'd0);
        send_frame(8'h3C, 1'b1, 1'b0);
        drain("3c_drain");
        check_eq("3c_data", 32'(uart_rx_data), 32'h3C);
        check_eq("3c_flag", 32'(uart_flag), 32'd1);

        // Reset during data bit 4 of 8'h77, then a good 8'h81.
        good_before = good_seen;
        err_before  = err_seen;
        d = 8'h77;
        uart_rx = 1'b0;
        repeat (N) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            uart_rx = d[i];
            repeat (N) @(negedge clk);
        end
        uart_rx = d[4];
        repeat (N / 2) @(negedge clk);
        rst = 1'b1;
        model_flag = 1'b0;
        model_data = 8'h00;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        uart_rx = 1'b1;
        repeat (12 * N) @(negedge clk);
        check_eq("abort_no_byte", 32'(good_seen - good_before), 32'd0);
        check_eq("abort_no_ferr", 32'(err_seen - err_before), 32'd0);
        send_frame(8'h81, 1'b1, 1'b0);
        drain("81_drain");
        check_eq("81_data", 32'(uart_rx_data), 32'h81);

        // Randomized frames: random data, gaps, mid-bit glitches, bad stops.
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom_range(0, 255));
            ok = ($urandom_range(0, 5) != 0);
            gl = 1'($urandom_range(0, 1));
            send_frame(d, ok, gl);
            if (ok) begin
                if ($urandom_range(0, 2) != 0) begin
                    uart_rx = 1'b1;
                    repeat ($urandom_range(1, 2 * N)) @(negedge clk);
                end
            end else begin
                repeat ($urandom_range(0, 30)) @(negedge clk);
                uart_rx = 1'b1;
                repeat ($urandom_range(4, 2 * N)) @(negedge clk);
            end
        end
        uart_rx = 1'b1;
        drain("rand_drain");

        // ---------------- final report ----------------
        repeat (2 * N) @(negedge clk);
        check_eq("total_good", 32'(good_seen), 32'(exp_good));
        check_eq("total_ferr", 32'(err_seen), 32'(exp_err));
        check_eq("end_busy", 32'(busy), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 5208, clock cycles per UART bit (50 MHz / 9600 baud); legal values are even and >= 8.
REQ-002 SHALL have port clk  input  1  system clock; every register is clocked on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, reset is synchronous and active-high.
REQ-004 SHALL have port uart_rx  input  1  asynchronous serial line, idle high, 8N1 format, LSB first.
REQ-005 SHALL have port uart_rx_data  output  8  last correctly framed byte.
REQ-006 SHALL have port uart_signal  output  1  one-cycle pulse: new byte valid on uart_rx_data.
REQ-007 SHALL have port uart_flag  output  1  operand select for ID write target; 0 = operand1, 1 = operand2.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-010 SHALL pass uart_rx through a 2-flop synchronizer; all logic uses only the synchronized value rx_s.
REQ-011 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH; a bit counter (0..7); and a cycle counter cnt (0..CLKS_PER_BIT-1).
REQ-012 IDLE: when rx_s==0, go to START with cnt=0; otherwise stay in IDLE.
REQ-013 START: when cnt==CLKS_PER_BIT/2-1, sample rx_s. If 0, go to DATA with cnt=0 and bit=0. If 1, treat it as a glitch and return to IDLE with no output.
REQ-014 DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into shift-register bit[bit] (LSB first) and reset cnt to 0. After bit 7, go to STOP.
REQ-015 STOP: when cnt==CLKS_PER_BIT-1, sample rx_s. If 1, load uart_rx_data from the shift register, pulse uart_signal, toggle uart_flag, and go to IDLE. If 0, pulse frame_err, leave uart_rx_data and uart_flag unchanged, and go to WAIT_HIGH.
REQ-016 WAIT_HIGH: stay while rx_s==0; go to IDLE on the first cycle rx_s==1. This prevents a break condition from being taken as a start bit.
REQ-017 uart_signal and frame_err SHALL be registered, high for exactly one cycle, and never high in the same cycle.
REQ-018 uart_rx_data and uart_signal SHALL be updated on the same clock edge, so data is valid during the pulse; uart_rx_data then holds until the next good frame.
REQ-019 uart_flag SHALL toggle on the same edge that uart_signal rises. During the pulse it therefore shows the target register for the next byte; ID uses the value from before the toggle.
REQ-020 Latency: uart_signal SHALL rise exactly 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles after the first clk edge at which uart_rx is sampled low.
REQ-021 Back-to-back frames: a start bit arriving immediately after the stop-bit sample point SHALL be received without loss, with no idle gap required beyond the second half of the stop bit.
REQ-022 cnt SHALL reset to 0 on every state transition and SHALL never exceed CLKS_PER_BIT-1.
REQ-023 uart_rx changes mid-bit (other than at the START sample) SHALL have no effect; only the sample points in REQ-013..REQ-015 are used.

Reset
REQ-024 While rst is high, the block SHALL hold: state=IDLE, cnt=0, bit=0, shift register=0, both sync flops=1, uart_rx_data=8'h00, uart_signal=0, uart_flag=0, frame_err=0, busy=0.
REQ-025 rst asserted mid-frame SHALL abort the frame on the next edge with no uart_signal or frame_err pulse. After release, reception resumes from IDLE, and any remaining frame bits may be taken as a new start.

Verification (CLKS_PER_BIT=16)
REQ-026 Send byte 8'hA5 with correct framing. Required: one uart_signal pulse at cycle 2+8+144+1=155 after the start edge; uart_rx_data=8'hA5; uart_flag changes 0->1.
REQ-027 Send 8'h12 then 8'h34 back-to-back. Required: two pulses carrying 8'h12 and 8'h34; uart_flag goes 0->1->0.
REQ-028 Drive a 4-cycle low glitch on an idle line. Required: return to IDLE at the START sample point, busy then low; no uart_signal or frame_err pulse.
REQ-029 Send 8'hFF with stop bit 0, holding the line low for 40 more cycles, then send 8'h3C correctly. Required: one frame_err pulse; uart_rx_data and uart_flag unchanged by the bad frame; WAIT_HIGH until the line returns high; then 8'h3C received with uart_flag 0->1.
REQ-030 Assert rst for 1 cycle during data bit 4 of 8'h77. Required: all outputs equal their reset values; no pulse from the aborted frame; the next correct frame 8'h81 is received.
REQ-031 Hold uart_rx=1 for 1000 cycles after reset. Required: busy=0, uart_signal=0, uart_rx_data=8'h00 throughout.
